ga_int_gen: RTL and testbench
=============================

Name: ga_int_gen

Overview:
- Raster interrupt generator for the GA40010 gate array.
- Counts HSYNC ends and raises the Z80 interrupt request every 52 lines.
- Resynchronises to VSYNC and honours CPU acknowledge and the RMR counter-clear strobe.
- Produces the set/reset events for the interrupt-request state and holds that state internally; its output drives the Z80 /INT line.

Parameters:
- INT_LINE, 52, counter value at which the interrupt fires and the counter wraps to 0.
- VSYNC_DELAY, 2, number of HSYNC ends after VSYNC rise before the resync is applied (1..3).
- CNT_W, 6, line counter width; must hold INT_LINE.

Ports:
- clock  in  1  system clock (16 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; all state updates and input sampling occur only when ce=1.
- hsync  in  1  CRTC HSYNC level.
- vsync  in  1  CRTC VSYNC level.
- int_ack  in  1  one-ce pulse; Z80 interrupt acknowledge (M1 & IORQ).
- rmr_clr  in  1  one-ce pulse; RMR write with bit 4 set.
- int_n  out  1  interrupt request to the Z80, active low.

Behaviour:
- Reset (async, reset_n=0): counter=0, int request cleared (int_n=1), FSM=IDLE, hsync/vsync history registers=0.
- Edge detection uses registered copies sampled on ce cycles:
  - hs_end = hsync_d & ~hsync.
  - vs_rise = ~vsync_d & vsync.
- Normal count on hs_end: counter+1. If the result equals INT_LINE: counter=0 and set interrupt.
- VSYNC FSM states: IDLE, WAIT(n).
  - IDLE + vs_rise -> WAIT with n=VSYNC_DELAY.
  - Each hs_end decrements n.
  - On the hs_end where n reaches 0, apply the resync and return to IDLE.
  - vs_rise while in WAIT is ignored; no retrigger.
- Resync replaces the normal count on that hs_end:
  - Counter=0.
  - Set interrupt if the pre-event counter value was >=32 (bit 5 set); otherwise leave the interrupt unchanged.
- int_ack:
  - Clears the interrupt.
  - Clears counter bit 5, applied after this cycle's count/wrap/resync result.
- rmr_clr: counter=0 and interrupt cleared.
- Priority when events coincide, highest first:
  1. rmr_clr.
  2. Set (wrap or resync).
  3. int_ack clear.
  - If int_ack coincides with a set, the interrupt stays asserted, but the bit-5 clear on the counter still applies.
- Latency: int_n changes at the clock edge of the ce cycle in which the event is detected. One ce cycle after the hs_end sample, int_n is registered low.
- Output: int_n is the registered inverse of the interrupt state; no combinational path from any input to int_n.
- ce=0 holds all state, including edge history, so edges spanning ce gaps are still seen exactly once.
- Reset asserted mid-count or mid-WAIT aborts immediately to the reset values. No pending resync survives reset.

Optional Feature:
- Macro: GA_INT_GEN_DEBUG_EN.
- When defined, add two output ports:
  - dbg_cnt [CNT_W-1:0]: live counter value.
  - dbg_vs_wait [1:0]: remaining WAIT count, 0 in IDLE.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package ga_pkg holds:
  - Constants GA_INT_LINE=52, GA_VSYNC_DELAY=2, GA_LINE_CNT_W=6.
  - Enum vs_state_t {VS_IDLE, VS_WAIT}.
- Sub-module int_req_latch (set/clear with set priority, async active-low reset, ce) holds the interrupt-request bit.
- Counter and FSM stay in ga_int_gen.

Test Plan:
- Reset, then 52 hs_end pulses -> int_n low after the 52nd, counter=0; no assertion after pulses 1..51.
- int_n low, int_ack pulse -> int_n high next ce cycle; counter bit 5 cleared (e.g. counter 40 -> 8).
- Counter at 35, vs_rise then 2 hs_end -> counter=0, int_n goes low on the 2nd hs_end. Repeat with counter at 20 -> counter=0, int_n stays high.
- Counter at 51, int_ack in the same ce cycle as hs_end -> int_n low (set wins), counter=0.
- Counter at 30, int_n low, rmr_clr coinciding with hs_end -> counter=0, int_n high.
- reset_n low mid-WAIT (after 1 hs_end), release, 1 hs_end -> no resync, counter=1; ce held low across an hsync pulse still counts exactly one hs_end.

Source files
------------

// File: rtl/ga_pkg.sv
// Shared constants and types for the GA40010 raster interrupt logic.
package ga_pkg;

    localparam int unsigned GA_INT_LINE    = 52;
    localparam int unsigned GA_VSYNC_DELAY = 2;
    localparam int unsigned GA_LINE_CNT_W  = 6;

    typedef enum logic {
        VS_IDLE,
        VS_WAIT
    } vs_state_t;

endpackage

// File: rtl/int_req_latch.sv
// Interrupt-request bit: set/clear flop, set wins over clear, updates only on ce.
module int_req_latch (
    input  logic clock,
    input  logic reset_n,
    input  logic ce,
    input  logic set,
    input  logic clr,
    output logic q
);

    // Request state register; set has priority over clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else if (ce) begin
            if (set) begin
                q <= 1'b1;
            end else if (clr) begin
                q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ga_int_gen.sv
// Raster interrupt generator: counts HSYNC ends, requests a Z80 interrupt
// every INT_LINE lines, resynchronises to VSYNC, honours ack and RMR clear.
// Optional debug ports are enabled by defining GA_INT_GEN_DEBUG_EN.
module ga_int_gen
    import ga_pkg::*;
#(
    parameter int unsigned INT_LINE    = GA_INT_LINE,
    parameter int unsigned VSYNC_DELAY = GA_VSYNC_DELAY,
    parameter int unsigned CNT_W       = GA_LINE_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             int_ack,
    input  logic             rmr_clr,
    output logic             int_n
`ifdef GA_INT_GEN_DEBUG_EN
    ,
    output logic [CNT_W-1:0] dbg_cnt,
    output logic [1:0]       dbg_vs_wait
`endif
);

    localparam int unsigned HI_BIT = 5;

    logic             hsync_d;
    logic             vsync_d;
    logic             hs_end;
    logic             vs_rise;
    vs_state_t        state_q;
    vs_state_t        state_d;
    logic [1:0]       wait_q;
    logic [1:0]       wait_d;
    logic             resync;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             set_req;
    logic             int_req;

    assign hs_end  = ce & hsync_d & ~hsync;
    assign vs_rise = ce & ~vsync_d & vsync;

    // Sync history, VSYNC FSM and line counter registers; all hold when ce=0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync_d <= 1'b0;
            vsync_d <= 1'b0;
            state_q <= VS_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else if (ce) begin
            hsync_d <= hsync;
            vsync_d <= vsync;
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // VSYNC resync FSM: arm on vs_rise, count down on hs_end, fire at zero.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        resync  = 1'b0;
        case (state_q)
            VS_IDLE: begin
                if (vs_rise) begin
                    state_d = VS_WAIT;
                    wait_d  = 2'(VSYNC_DELAY);
                end
            end
            VS_WAIT: begin
                if (hs_end) begin
                    if (wait_q == 2'd1) begin
                        resync  = 1'b1;
                        state_d = VS_IDLE;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = VS_IDLE;
                wait_d  = '0;
            end
        endcase
    end

    // Counter next value and interrupt set; ack's bit-5 clear is applied on
    // top of the count/wrap/resync result, and rmr_clr overrides everything.
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = cnt_q;
        set_req = 1'b0;
        if (hs_end) begin
            if (resync) begin
                cnt_d   = '0;
                set_req = cnt_q[HI_BIT];
            end else if (cnt_inc == CNT_W'(INT_LINE)) begin
                cnt_d   = '0;
                set_req = 1'b1;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        if (int_ack) begin
            cnt_d[HI_BIT] = 1'b0;
        end
        if (rmr_clr) begin
            cnt_d = '0;
        end
    end

    int_req_latch u_req (
        .clock   (clock),
        .reset_n (reset_n),
        .ce      (ce),
        .set     (set_req & ~rmr_clr),
        .clr     (int_ack | rmr_clr),
        .q       (int_req)
    );

    assign int_n = ~int_req;

`ifdef GA_INT_GEN_DEBUG_EN
    assign dbg_cnt     = cnt_q;
    assign dbg_vs_wait = wait_q;
`endif

endmodule

// File: tb/tb_ga_int_gen.sv
// Self-checking bench for ga_int_gen: directed scenarios with literal
// expectations plus randomized traffic against a behavioural line model.
module tb_ga_int_gen;

    logic clock;
    logic reset_n;
    logic ce;
    logic hsync;
    logic vsync;
    logic int_ack;
    logic rmr_clr;
    logic int_n;
`ifdef GA_INT_GEN_DEBUG_EN
    logic [5:0] dbg_cnt;
    logic [1:0] dbg_vs_wait;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_cnt;
    int m_wait;   // 0 = not waiting, else hs_ends left before resync
    bit m_irq;
    bit m_hs;
    bit m_vs;

    ga_int_gen dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ce      (ce),
        .hsync   (hsync),
        .vsync   (vsync),
        .int_ack (int_ack),
        .rmr_clr (rmr_clr),
        .int_n   (int_n)
`ifdef GA_INT_GEN_DEBUG_EN
        ,
        .dbg_cnt     (dbg_cnt),
        .dbg_vs_wait (dbg_vs_wait)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: one line-event step per enabled clock.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0; m_wait = 0; m_irq = 0; m_hs = 0; m_vs = 0;
        end else if (ce) begin
            bit he, vr, waiting, set;
            int c;
            he = m_hs && !hsync;
            vr = !m_vs && vsync;
            m_hs = hsync;
            m_vs = vsync;
            waiting = (m_wait != 0);
            set = 0;
            c = m_cnt;
            if (he) begin
                if (waiting) m_wait = m_wait - 1;
                if (waiting && m_wait == 0) begin
                    set = (c >= 32);
                    c = 0;
                end else begin
                    c = c + 1;
                    if (c == 52) begin
                        c = 0;
                        set = 1;
                    end
                end
            end
            if (vr && !waiting) m_wait = 2;
            if (int_ack && c >= 32) c = c - 32;
            if (rmr_clr) begin
                c = 0;
                m_irq = 0;
            end else if (set) begin
                m_irq = 1;
            end else if (int_ack) begin
                m_irq = 0;
            end
            m_cnt = c;
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clock) begin
        total++;
        if (int_n !== !m_irq) begin
            bad++;
            $display("FAIL model_int_n t=%0t got=%b exp=%b", $time, int_n, !m_irq);
        end
`ifdef GA_INT_GEN_DEBUG_EN
        total++;
        if (dbg_cnt !== 6'(m_cnt) || dbg_vs_wait !== 2'(m_wait)) begin
            bad++;
            $display("FAIL model_dbg t=%0t cnt=%0d exp=%0d wait=%0d exp=%0d",
                     $time, dbg_cnt, m_cnt, dbg_vs_wait, m_wait);
        end
`endif
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // One full HSYNC pulse; ack/rmr can be made to coincide with its end.
    task automatic hs_pulse(input logic ack_end, input logic rmr_end);
        hsync = 1'b1; cyc(); cyc();
        hsync = 1'b0; int_ack = ack_end; rmr_clr = rmr_end; cyc();
        int_ack = 1'b0; rmr_clr = 1'b0; cyc();
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) hs_pulse(1'b0, 1'b0);
    endtask

    task automatic ack();
        int_ack = 1'b1; cyc(); int_ack = 1'b0; cyc();
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b1; hsync = 1'b0; vsync = 1'b0;
        int_ack = 1'b0; rmr_clr = 1'b0;
        cyc(); cyc();
        chk("reset_int_n", int_n, 1'b1);
        reset_n = 1'b1; cyc();

        // 52 lines -> interrupt exactly on the 52nd
        for (int i = 1; i <= 51; i++) begin
            hs_pulse(1'b0, 1'b0);
            chk("no_early_int", int_n, 1'b1);
        end
        hs_pulse(1'b0, 1'b0);
        chk("int_at_52", int_n, 1'b0);

        // ack clears request; counter 40 -> 8 so 44 more lines fire
        ack();
        chk("ack_clears", int_n, 1'b1);
        pulses(40);
        ack();
        pulses(43);
        chk("after_ack_43", int_n, 1'b1);
        hs_pulse(1'b0, 1'b0);
        chk("after_ack_44", int_n, 1'b0);
        ack();

        // resync with counter 35 -> sets; with counter 20 -> no set
        pulses(35);
        vsync = 1'b1; cyc();
        hs_pulse(1'b0, 1'b0);
        chk("resync35_first", int_n, 1'b1);
        hs_pulse(1'b0, 1'b0);
        chk("resync35_set", int_n, 1'b0);
        vsync = 1'b0; ack();
        pulses(20);
        vsync = 1'b1; cyc();
        pulses(2);
        chk("resync20_noset", int_n, 1'b1);
        vsync = 1'b0; cyc();
        pulses(51);
        chk("resync20_cnt0_a", int_n, 1'b1);
        hs_pulse(1'b0, 1'b0);
        chk("resync20_cnt0_b", int_n, 1'b0);
        ack();

        // counter 51, ack with hs_end -> set wins
        pulses(51);
        chk("pre51", int_n, 1'b1);
        hs_pulse(1'b1, 1'b0);
        chk("set_beats_ack", int_n, 1'b0);

        // counter 30 with request pending, rmr_clr with hs_end
        pulses(30);
        chk("pending_30", int_n, 1'b0);
        hs_pulse(1'b0, 1'b1);
        chk("rmr_clears", int_n, 1'b1);

        // reset mid-WAIT discards the pending resync
        vsync = 1'b1; cyc();
        hs_pulse(1'b0, 1'b0);
        reset_n = 1'b0; cyc();
        vsync = 1'b0; reset_n = 1'b1; cyc();
        chk("reset_midwait", int_n, 1'b1);
        hs_pulse(1'b0, 1'b0);
        chk("no_resync_after_reset", int_n, 1'b1);
        // falling HSYNC inside a ce gap is still counted once -> counter 2
        hsync = 1'b1; cyc();
        ce = 1'b0; hsync = 1'b0; cyc(); cyc();
        ce = 1'b1; cyc(); cyc();
        pulses(49);
        chk("ce_gap_49", int_n, 1'b1);
        hs_pulse(1'b0, 1'b0);
        chk("ce_gap_50", int_n, 1'b0);
        ack();

        // randomized traffic, checked by the every-cycle compare
        for (int i = 0; i < 6000; i++) begin
            ce      = ($urandom % 4) != 0;
            if ($urandom % 3 == 0) hsync = ~hsync;
            if ($urandom % 97 == 0) vsync = ~vsync;
            int_ack = ($urandom % 50) == 0;
            rmr_clr = ($urandom % 300) == 0;
            reset_n = ($urandom % 2000) != 0;
            cyc();
        end
        reset_n = 1'b1; ce = 1'b1; int_ack = 1'b0; rmr_clr = 1'b0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
